lvl_states_bram_arbiter: RTL and testbench

//  Shares the single-port lvls-states BRAM among NUM_REQ sequencers (backtrack-level

---
 rtl/lvl_states_bram_arbiter_if.sv | 26 ++
 rtl/lvl_states_bram_arbiter.sv | 135 +++++++++++++
 tb/tb_lvl_states_bram_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lvl_states_bram_arbiter_if.sv
// Requester-side bus of the lvls-states BRAM arbiter: per-requester apply/strobes in, grant and read data out.
// The master modport drives the request side; the slave modport sits on the arbiter.
interface lvl_states_bram_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 30,
    parameter int ADDR_W  = 9
);
    logic [NUM_REQ-1:0]        req_apply_i;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ-1:0]        req_re_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic [DATA_W-1:0]         rdata_o;
    logic [NUM_REQ-1:0]        rvalid_o;

    modport master (
        output req_apply_i, req_we_i, req_re_i, req_addr_i, req_data_i,
        input  grant_o, rdata_o, rvalid_o
    );

    modport slave (
        input  req_apply_i, req_we_i, req_re_i, req_addr_i, req_data_i,
        output grant_o, rdata_o, rvalid_o
    );
endinterface

// File: rtl/lvl_states_bram_arbiter.sv
// Round-robin, burst-locked arbiter for the single-port lvls-states BRAM. Grant 1 cycle after apply;
// strobes registered to RAM in 1 cycle, read data back 2 cycles after the strobe; no stall, losers simply wait.
module lvl_states_bram_arbiter #(
    parameter int NUM_REQ                = 3,
    parameter int WIDTH_LVL_STATES       = 30,
    parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    lvl_states_bram_arbiter_if.slave          bus,
    output logic                              busy_o,
    output logic                              ram_we_o,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_o,
    output logic [WIDTH_LVL_STATES-1:0]       ram_data_o,
    input  logic [WIDTH_LVL_STATES-1:0]       ram_data_i
);
    localparam int DW  = WIDTH_LVL_STATES;
    localparam int AW  = ADDR_WIDTH_LVLS_STATES;
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [1:0]         drain_cnt, drain_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [IDW-1:0]     last, last_nxt;
    logic [IDW-1:0]     pick, cand;
    logic               pick_vld;

    logic               acc, wr, rd;
    logic               rd_vld1, rd_vld2;
    logic [IDW-1:0]     rd_id1, rd_id2;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DW-1:0]      rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            drain_cnt <= 2'd0;
            grant_q   <= '0;
            last      <= IDW'(NUM_REQ - 1);
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            grant_q   <= grant_nxt;
            last      <= last_nxt;
        end
    end

    // `last` doubles as the owner id while a grant is held.
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        grant_nxt = grant_q;
        last_nxt  = last;
        pick      = last;
        pick_vld  = 1'b0;
        cand      = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(last) + k) % NUM_REQ);
            if (!pick_vld && bus.req_apply_i[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt       = GRANT;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    last_nxt        = pick;
                end
            end
            GRANT: begin
                if (!bus.req_apply_i[last]) begin
                    state_nxt = DRAIN;
                    grant_nxt = '0;
                    drain_nxt = 2'd0;
                end
            end
            DRAIN: begin
                if (drain_cnt == 2'd1) begin
                    state_nxt = IDLE;
                    drain_nxt = 2'd0;
                end else begin
                    drain_nxt = drain_cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // Strobes in the cycle apply drops are ignored; write wins over a simultaneous read.
    assign acc = (state == GRANT) && bus.req_apply_i[last];
    assign wr  = acc && bus.req_we_i[last];
    assign rd  = acc && bus.req_re_i[last] && !bus.req_we_i[last];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
            rd_vld1    <= 1'b0;
            rd_vld2    <= 1'b0;
            rd_id1     <= '0;
            rd_id2     <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            ram_we_o <= wr;
            if (acc && (bus.req_we_i[last] || bus.req_re_i[last])) begin
                ram_addr_o <= bus.req_addr_i[int'(last)*AW +: AW];
                ram_data_o <= bus.req_data_i[int'(last)*DW +: DW];
            end
            rd_vld1  <= rd;
            rd_id1   <= last;
            rd_vld2  <= rd_vld1;
            rd_id2   <= rd_id1;
            rvalid_q <= '0;
            if (rd_vld2) begin
                rvalid_q[rd_id2] <= 1'b1;
                rdata_q          <= ram_data_i;
            end
        end
    end

    assign bus.grant_o  = grant_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign busy_o       = (state != IDLE);
endmodule

// File: tb/tb_lvl_states_bram_arbiter.sv
// Directed bench for lvl_states_bram_arbiter: vector table for burst/arbitration flows, hand sequences for corner cases.
module tb_lvl_states_bram_arbiter;
    localparam int NR = 3;
    localparam int DW = 30;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          busy, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    lvl_states_bram_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

    lvl_states_bram_arbiter #(
        .NUM_REQ(NR), .WIDTH_LVL_STATES(DW), .ADDR_WIDTH_LVLS_STATES(AW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy_o(busy),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: preloaded with 0x1000_0000 + address on the first edge, 1-cycle read latency.
    logic [DW-1:0] mem [0:511];
    logic          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= 30'h1000_0000 + 30'(i);
            mem_init <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ap, input logic [2:0] we, input logic [2:0] re,
                         input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        bus.req_apply_i = ap;
        bus.req_we_i    = we;
        bus.req_re_i    = re;
        bus.req_addr_i  = {NR{ad}};
        bus.req_data_i  = {NR{dt}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [2:0]    ap, we, re;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        logic [2:0]    e_grant;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [2:0]    e_rvalid;
        logic [DW-1:0] e_rdata;
        logic          e_busy;
    } vec_t;

    vec_t tv [0:18];

    function automatic vec_t v(input logic [2:0] ap, input logic [2:0] we, input logic [2:0] re,
                               input logic [AW-1:0] ad, input logic [DW-1:0] dt,
                               input logic [2:0] eg, input logic ew, input logic [AW-1:0] ea,
                               input logic [DW-1:0] ed, input logic [2:0] ev,
                               input logic [DW-1:0] er, input logic eb);
        vec_t r;
        r.ap = ap; r.we = we; r.re = re; r.ad = ad; r.dt = dt;
        r.e_grant = eg; r.e_we = ew; r.e_addr = ea; r.e_wdata = ed;
        r.e_rvalid = ev; r.e_rdata = er; r.e_busy = eb;
        return r;
    endfunction

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(tv[i].ap, tv[i].we, tv[i].re, tv[i].ad, tv[i].dt);
            tick();
            chk($sformatf("row%0d grant", i),  32'(bus.grant_o),  32'(tv[i].e_grant));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we),       32'(tv[i].e_we));
            chk($sformatf("row%0d addr", i),   32'(ram_addr),     32'(tv[i].e_addr));
            chk($sformatf("row%0d wdata", i),  32'(ram_wdata),    32'(tv[i].e_wdata));
            chk($sformatf("row%0d rvalid", i), 32'(bus.rvalid_o), 32'(tv[i].e_rvalid));
            chk($sformatf("row%0d busy", i),   32'(busy),         32'(tv[i].e_busy));
            if (tv[i].e_rvalid != 3'b000)
                chk($sformatf("row%0d rdata", i), 32'(bus.rdata_o), 32'(tv[i].e_rdata));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Write then three pipelined reads; the last read returns during DRAIN.
        tv[0]  = v(3'b001, 3'b000, 3'b000, 9'd0, 30'h0,   3'b001, 1'b0, 9'd0, 30'h0,   3'b000, 30'h0,         1'b1);
        tv[1]  = v(3'b001, 3'b001, 3'b000, 9'd5, 30'h155, 3'b001, 1'b1, 9'd5, 30'h155, 3'b000, 30'h0,         1'b1);
        tv[2]  = v(3'b001, 3'b000, 3'b001, 9'd5, 30'h155, 3'b001, 1'b0, 9'd5, 30'h155, 3'b000, 30'h0,         1'b1);
        tv[3]  = v(3'b001, 3'b000, 3'b001, 9'd6, 30'h155, 3'b001, 1'b0, 9'd6, 30'h155, 3'b000, 30'h0,         1'b1);
        tv[4]  = v(3'b001, 3'b000, 3'b001, 9'd7, 30'h155, 3'b001, 1'b0, 9'd7, 30'h155, 3'b001, 30'h155,       1'b1);
        tv[5]  = v(3'b000, 3'b000, 3'b000, 9'd7, 30'h155, 3'b000, 1'b0, 9'd7, 30'h155, 3'b001, 30'h1000_0006, 1'b1);
        tv[6]  = v(3'b000, 3'b000, 3'b000, 9'd7, 30'h155, 3'b000, 1'b0, 9'd7, 30'h155, 3'b001, 30'h1000_0007, 1'b1);
        tv[7]  = v(3'b000, 3'b000, 3'b000, 9'd7, 30'h155, 3'b000, 1'b0, 9'd7, 30'h155, 3'b000, 30'h0,         1'b0);
        // Round-robin: req0 first out of reset, 3-cycle gap, then req1, then req2 among all three.
        tv[8]  = v(3'b011, 3'b000, 3'b000, 9'd0, 30'h0, 3'b001, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[9]  = v(3'b011, 3'b000, 3'b000, 9'd0, 30'h0, 3'b001, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[10] = v(3'b010, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[11] = v(3'b010, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[12] = v(3'b010, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b0);
        tv[13] = v(3'b010, 3'b000, 3'b000, 9'd0, 30'h0, 3'b010, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[14] = v(3'b000, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[15] = v(3'b111, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[16] = v(3'b111, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b0);
        tv[17] = v(3'b111, 3'b000, 3'b000, 9'd0, 30'h0, 3'b100, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);
        tv[18] = v(3'b000, 3'b000, 3'b000, 9'd0, 30'h0, 3'b000, 1'b0, 9'd0, 30'h0, 3'b000, 30'h0, 1'b1);

        reset_dut();
        chk("reset grant",  32'(bus.grant_o),  32'h0);
        chk("reset rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("reset rdata",  32'(bus.rdata_o),  32'h0);
        chk("reset busy",   32'(busy),         32'h0);
        chk("reset ram_we", 32'(ram_we),       32'h0);
        chk("reset addr",   32'(ram_addr),     32'h0);
        chk("reset wdata",  32'(ram_wdata),    32'h0);
        run_rows(0, 7);
        chk("mem5 written", 32'(mem[5]), 32'h155);

        reset_dut();
        run_rows(8, 18);
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (3) tick();

        // Non-granted requester's strobes must not reach the RAM; its apply stays pending.
        reset_dut();
        drive(3'b101, 3'b000, 3'b000, '0, '0);
        tick();
        chk("t4 grant req0", 32'(bus.grant_o), 32'h1);
        bus.req_we_i   = 3'b101;
        bus.req_addr_i = {9'd9, 9'd0, 9'd4};
        bus.req_data_i = {30'h99, 30'h0, 30'h44};
        tick();
        chk("t4 ram_we", 32'(ram_we),    32'h1);
        chk("t4 addr",   32'(ram_addr),  32'd4);
        chk("t4 wdata",  32'(ram_wdata), 32'h44);
        bus.req_we_i = 3'b100;
        tick();
        chk("t4 ram_we idle", 32'(ram_we),   32'h0);
        chk("t4 addr hold",   32'(ram_addr), 32'd4);
        bus.req_apply_i = 3'b100;
        bus.req_we_i    = 3'b000;
        tick();
        chk("t4 release", 32'(bus.grant_o), 32'h0);
        repeat (3) tick();
        chk("t4 pending req2", 32'(bus.grant_o), 32'h4);
        bus.req_apply_i = 3'b000;
        repeat (4) tick();
        chk("t4 mem9 untouched", 32'(mem[9]), 32'h1000_0009);
        chk("t4 mem4 written",   32'(mem[4]), 32'h44);

        // Reset mid-read: outputs clear immediately, the read never completes.
        reset_dut();
        drive(3'b001, 3'b000, 3'b000, '0, '0);
        tick();
        drive(3'b001, 3'b000, 3'b001, 9'd6, '0);
        tick();
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        tick();
        #1 rst = 1'b0;
        #1;
        chk("t5 async grant",  32'(bus.grant_o),  32'h0);
        chk("t5 async busy",   32'(busy),         32'h0);
        chk("t5 async addr",   32'(ram_addr),     32'h0);
        chk("t5 async rvalid", 32'(bus.rvalid_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5 no rvalid %0d", i), 32'(bus.rvalid_o), 32'h0);
        end
        drive(3'b011, 3'b000, 3'b000, '0, '0);
        tick();
        chk("t5 req0 favoured", 32'(bus.grant_o), 32'h1);

        // we and re together: write happens, no read data returned.
        reset_dut();
        drive(3'b001, 3'b000, 3'b000, '0, '0);
        tick();
        drive(3'b001, 3'b001, 3'b001, 9'd3, 30'h333);
        tick();
        chk("t6 ram_we", 32'(ram_we),   32'h1);
        chk("t6 addr",   32'(ram_addr), 32'd3);
        drive(3'b001, 3'b000, 3'b000, 9'd3, 30'h333);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6 no rvalid %0d", i), 32'(bus.rvalid_o), 32'h0);
        end
        drive(3'b000, 3'b000, 3'b000, '0, '0);
        repeat (4) tick();
        chk("t6 mem3 written", 32'(mem[3]), 32'h333);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
